// File: rtl/lcd_text_formatter_if.sv
// Request/frame bundle between the IMUL2 result path, the formatter and the LCD driver.
interface lcd_text_formatter_if;
    logic         iStart;
    logic [15:0]  iA;
    logic [15:0]  iB;
    logic [31:0]  iResult;
    logic [256:0] oChars;
    logic         oBusy;
    logic         oDone;

    modport master (
        output iStart, iA, iB, iResult,
        input  oChars, oBusy, oDone
    );

    modport slave (
        input  iStart, iA, iB, iResult,
        output oChars, oBusy, oDone
    );
endinterface

// File: rtl/lcd_text_formatter.sv
// Formats A, B and A*B as right-aligned decimal into a 32-char LCD frame via one shared double-dabble engine.
// Fixed 100-cycle latency from accepted start to new frame; starts arriving while busy are dropped.
module lcd_text_formatter (
    input  logic                 Clock,
    input  logic                 Reset,
    lcd_text_formatter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

    localparam logic [255:0] BLANK    = {32{8'h20}};
    localparam logic [255:0] TEMPLATE = {"A=", {6{8'h20}}, "B=", {6{8'h20}}, "R=", {14{8'h20}}};

    state_t        state_q;
    state_t        state_d;
    logic [4:0]    step_q;
    logic [1:0]    op_idx_q;
    logic [15:0]   b_q;
    logic [31:0]   r_q;
    logic [31:0]   bin_q;
    logic [39:0]   bcd_q;
    logic [39:0]   bcd_adj;
    logic [255:0]  work_q;
    logic [255:0]  chars_q;
    logic          done_q;
    logic [7:0]    ascii [10];
    logic          lead;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.iStart) state_d = CONV;
            CONV:    if (step_q == 5'd31) state_d = WRITE;
            WRITE:   state_d = (op_idx_q == 2'd2) ? DONE : CONV;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Digits above the first nonzero one are blanked; digit 0 always prints.
    always_comb begin
        lead = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            ascii[i] = lead ? 8'h20 : {4'h3, bcd_q[4*i +: 4]};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q   <= '0;
            op_idx_q <= '0;
            b_q      <= '0;
            r_q      <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            work_q   <= BLANK;
            chars_q  <= BLANK;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.iStart) begin
                        b_q      <= bus.iB;
                        r_q      <= bus.iResult;
                        bin_q    <= {16'h0000, bus.iA};
                        bcd_q    <= '0;
                        step_q   <= '0;
                        op_idx_q <= '0;
                        work_q   <= TEMPLATE;
                    end
                end
                CONV: begin
                    bcd_q  <= {bcd_adj[38:0], bin_q[31]};
                    bin_q  <= {bin_q[30:0], 1'b0};
                    step_q <= step_q + 5'd1;
                end
                WRITE: begin
                    case (op_idx_q)
                        2'd0: begin
                            for (int d = 0; d < 5; d++) work_q[8*(25+d) +: 8] <= ascii[d];
                            bin_q <= {16'h0000, b_q};
                        end
                        2'd1: begin
                            for (int d = 0; d < 5; d++) work_q[8*(17+d) +: 8] <= ascii[d];
                            bin_q <= r_q;
                        end
                        default: begin
                            for (int d = 0; d < 10; d++) work_q[8*(4+d) +: 8] <= ascii[d];
                            bin_q <= '0;
                        end
                    endcase
                    bcd_q    <= '0;
                    step_q   <= '0;
                    op_idx_q <= op_idx_q + 2'd1;
                end
                DONE: begin
                    chars_q <= work_q;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oChars = {1'b0, chars_q};
    assign bus.oBusy  = (state_q != IDLE);
    assign bus.oDone  = done_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Bench for lcd_text_formatter: vector table plus scoreboard of expected frames, with busy/reset corner sequences.
module tb_lcd_text_formatter;

    logic Clock = 1'b0;
    logic Reset;

    lcd_text_formatter_if bus();

    lcd_text_formatter dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  b;
        logic [31:0]  r;
        logic [127:0] l1;
        logic [127:0] l2;
    } vec_t;

    localparam logic [256:0] BLANK = {1'b0, {32{8'h20}}};

    vec_t         vecs [6];
    logic [256:0] sb [$];
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] r,
                            input bit push, input logic [127:0] l1, input logic [127:0] l2);
        @(negedge Clock);
        bus.iStart  = 1'b1;
        bus.iA      = a;
        bus.iB      = b;
        bus.iResult = r;
        if (push) sb.push_back({1'b0, l1, l2});
        @(negedge Clock);
        bus.iStart  = 1'b0;
        bus.iA      = 16'($urandom);
        bus.iB      = 16'($urandom);
        bus.iResult = $urandom;
    endtask

    // Counts cycles after the accepting edge until oDone; optionally injects a start mid-conversion.
    task automatic wait_done(input int poke_at, input logic [256:0] old, output int lat,
                             output bit busy_ok, output bit hold_ok);
        lat     = -1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clock);
            if (poke_at > 0 && k == poke_at) begin
                bus.iStart  = 1'b1;
                bus.iA      = 16'd999;
                bus.iB      = 16'd111;
                bus.iResult = 32'd110889;
            end else if (poke_at > 0 && k == poke_at + 1) begin
                bus.iStart = 1'b0;
            end
            if (bus.oDone) begin
                lat = k;
                break;
            end
            if (!bus.oBusy) busy_ok = 1'b0;
            if (bus.oChars !== old) hold_ok = 1'b0;
        end
    endtask

    task automatic check_frame(input string name);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: got oDone with no frame expected", name);
        end else begin
            checks--;
            chk(name, bus.oChars, sb.pop_front());
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge Clock);
            if (bus.oDone) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           n;
        int           t1;
        int           t2;
        bit           busy_ok;
        bit           hold_ok;
        logic [256:0] old;

        vecs[0] = '{16'd3,     16'd5,     32'd15,         "A=    3 B=    5 ", "R=        15    "};
        vecs[1] = '{16'd65535, 16'd65535, 32'd4294836225, "A=65535 B=65535 ", "R=4294836225    "};
        vecs[2] = '{16'd0,     16'd7,     32'd0,          "A=    0 B=    7 ", "R=         0    "};
        vecs[3] = '{16'd100,   16'd10,    32'd1000,       "A=  100 B=   10 ", "R=      1000    "};
        vecs[4] = '{16'd10000, 16'd1,     32'd10000,      "A=10000 B=    1 ", "R=     10000    "};
        vecs[5] = '{16'd1,     16'd0,     32'd0,          "A=    1 B=    0 ", "R=         0    "};

        Reset       = 1'b1;
        bus.iStart  = 1'b0;
        bus.iA      = '0;
        bus.iB      = '0;
        bus.iResult = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        chk("reset_chars", bus.oChars, BLANK);
        chk("reset_busy", 257'(bus.oBusy), 257'd0);
        chk("reset_done", 257'(bus.oDone), 257'd0);

        for (int i = 0; i < 6; i++) begin
            old = bus.oChars;
            start_op(vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, vecs[i].l1, vecs[i].l2);
            chk($sformatf("v%0d_busy_start", i), 257'(bus.oBusy), 257'd1);
            wait_done(0, old, lat, busy_ok, hold_ok);
            chk($sformatf("v%0d_latency", i), 257'(lat), 257'd100);
            chk($sformatf("v%0d_busy_hold", i), 257'(busy_ok), 257'd1);
            chk($sformatf("v%0d_frame_hold", i), 257'(hold_ok), 257'd1);
            check_frame($sformatf("v%0d_frame", i));
            chk($sformatf("v%0d_busy_after", i), 257'(bus.oBusy), 257'd0);
            @(negedge Clock);
            chk($sformatf("v%0d_done_pulse", i), 257'(bus.oDone), 257'd0);
        end

        // Start while busy: second request must be dropped, not queued.
        old = bus.oChars;
        start_op(16'd12, 16'd34, 32'd408, 1'b1, "A=   12 B=   34 ", "R=       408    ");
        wait_done(40, old, lat, busy_ok, hold_ok);
        chk("busy_start_latency", 257'(lat), 257'd100);
        chk("busy_start_hold", 257'(hold_ok), 257'd1);
        check_frame("busy_start_frame");
        count_dones(150, n);
        chk("busy_start_no_extra_done", 257'(n), 257'd0);

        // Reset mid-conversion aborts and blanks the frame.
        start_op(16'd321, 16'd2, 32'd642, 1'b0, '0, '0);
        repeat (49) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midreset_chars", bus.oChars, BLANK);
        chk("midreset_busy", 257'(bus.oBusy), 257'd0);
        count_dones(120, n);
        chk("midreset_no_done", 257'(n), 257'd0);
        old = bus.oChars;
        start_op(16'd321, 16'd2, 32'd642, 1'b1, "A=  321 B=    2 ", "R=       642    ");
        wait_done(0, old, lat, busy_ok, hold_ok);
        chk("midreset_restart_latency", 257'(lat), 257'd100);
        check_frame("midreset_restart_frame");

        // iStart held high: back-to-back frames every 101 cycles.
        @(negedge Clock);
        bus.iStart  = 1'b1;
        bus.iA      = 16'd42;
        bus.iB      = 16'd2;
        bus.iResult = 32'd84;
        sb.push_back({1'b0, 128'("A=   42 B=    2 "), 128'("R=        84    ")});
        sb.push_back({1'b0, 128'("A=   42 B=    2 "), 128'("R=        84    ")});
        t1 = -1;
        t2 = -1;
        for (int k = 0; k <= 300; k++) begin
            @(negedge Clock);
            if (bus.oDone) begin
                check_frame("held_frame");
                if (t1 < 0) begin
                    t1 = k;
                end else begin
                    t2 = k;
                    break;
                end
            end
        end
        bus.iStart = 1'b0;
        chk("held_first_latency", 257'(t1), 257'd100);
        chk("held_period", 257'(t2 - t1), 257'd101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
